// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds fetched PC, PC+4 and instruction for decode,
// with flush > stall > load priority. Define IF_ID_PERF_EN to build the stall/flush counters.
`ifndef WIDTH
`define WIDTH 32
`endif

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [`WIDTH-1:0] pc_i,
  input  logic [`WIDTH-1:0] pc_plus4_i,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  output logic [`WIDTH-1:0] pc_o,
  output logic [`WIDTH-1:0] pc_plus4_o,
  output logic [31:0]       instr_o,
  output logic              valid_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);

  typedef struct packed {
    logic [`WIDTH-1:0] pc;
    logic [`WIDTH-1:0] pc4;
    logic [31:0]       instr;
    logic              vld;
  } ifid_t;

  ifid_t r_stage;
  ifid_t w_load;

  // An invalid fetch enters decode as a bubble rather than carrying stale data.
  always_comb begin
    w_load.pc    = pc_i;
    w_load.pc4   = pc_plus4_i;
    w_load.instr = instr_valid_i ? instr_i : NOP_INSTR;
    w_load.vld   = instr_valid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage.pc    <= '0;
      r_stage.pc4   <= '0;
      r_stage.instr <= NOP_INSTR;
      r_stage.vld   <= 1'b0;
    end else if (flush_i) begin
      // PC fields keep their old values; only the instruction is squashed.
      r_stage.instr <= NOP_INSTR;
      r_stage.vld   <= 1'b0;
    end else if (!stall_i) begin
      r_stage <= w_load;
    end
  end

  assign pc_o       = r_stage.pc;
  assign pc_plus4_o = r_stage.pc4;
  assign instr_o    = r_stage.instr;
  assign valid_o    = r_stage.vld;

`ifdef IF_ID_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_stall_evt;
  logic        w_flush_evt;

  // Only cycles that hold or squash a real instruction are counted.
  assign w_stall_evt = stall_i & ~flush_i & r_stage.vld;
  assign w_flush_evt = flush_i & r_stage.vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: each driven cycle pushes the expected ID-stage
// view; it is popped and compared one edge later.
module tb_if_id_reg;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef logic [128:0] obs_t; // {pc, pc4, instr, valid, stall_cnt, flush_cnt}

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] pc_plus4_i = '0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_o, pc_plus4_o, instr_o;
  logic        valid_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int total = 0;
  int bad = 0;

  obs_t sb[$];

  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_vld;
  logic [15:0] m_sc, m_fc;

  if_id_reg #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .pc_plus4_i(pc_plus4_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o), .valid_o(valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 if (clk_en) clk = ~clk;

  function automatic obs_t dut_obs();
    return {pc_o, pc_plus4_o, instr_o, valid_o, stall_cnt_o, flush_cnt_o};
  endfunction

  function automatic obs_t model_obs();
    return {m_pc, m_pc4, m_instr, m_vld, m_sc, m_fc};
  endfunction

  task automatic model_reset();
    m_pc = '0; m_pc4 = '0; m_instr = NOP; m_vld = 1'b0; m_sc = '0; m_fc = '0;
    sb.delete();
  endtask

  // Drive one cycle, advance the reference state, push the expectation.
  task automatic step(input logic st, input logic fl, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic [31:0] ins, input logic iv);
    @(negedge clk);
    stall_i = st; flush_i = fl; pc_i = pc; pc_plus4_i = pc4; instr_i = ins; instr_valid_i = iv;
    if (fl) begin
      if (PERF && m_vld && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      m_instr = NOP; m_vld = 1'b0;
    end else if (st) begin
      if (PERF && m_vld && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    end else begin
      m_pc = pc; m_pc4 = pc4; m_instr = iv ? ins : NOP; m_vld = iv;
    end
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e = {32'h0, 32'h0, NOP, 1'b0, 16'h0, 16'h0};
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL reset_state got=%h exp=%h", dut_obs(), e); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_load();
    obs_t e;
    step(1'b0, 1'b0, 32'h100, 32'h104, 32'h00500093, 1'b1);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL load got=%h exp=%h", dut_obs(), e); end
    total++;
    if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {32'h100, 32'h104, 32'h00500093, 1'b1}) begin
      bad++; $display("FAIL load_const got=%h/%h/%h/%b exp=100/104/00500093/1", pc_o, pc_plus4_o, instr_o, valid_o);
    end
  endtask

  task automatic test_stall();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h104, 32'h108, 32'h00A00113, 1'b1);
      e = sb.pop_front();
      total++;
      if (dut_obs() !== e) begin bad++; $display("FAIL stall%0d got=%h exp=%h", i, dut_obs(), e); end
    end
    total++;
    if ({pc_o, instr_o, valid_o} !== {32'h100, 32'h00500093, 1'b1}) begin
      bad++; $display("FAIL stall_hold got=%h/%h/%b exp=100/00500093/1", pc_o, instr_o, valid_o);
    end
    total++;
    if (stall_cnt_o !== (PERF ? 16'd3 : 16'd0)) begin
      bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt_o, PERF ? 3 : 0);
    end
  endtask

  task automatic test_flush_stall();
    obs_t e;
    step(1'b1, 1'b1, 32'h104, 32'h108, 32'h00A00113, 1'b1);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL flush_stall got=%h exp=%h", dut_obs(), e); end
    total++;
    if ({pc_o, instr_o, valid_o, flush_cnt_o} !== {32'h100, NOP, 1'b0, (PERF ? 16'd1 : 16'd0)}) begin
      bad++; $display("FAIL flush_stall_const got=%h/%h/%b/%0d exp=100/00000013/0/%0d",
                      pc_o, instr_o, valid_o, flush_cnt_o, PERF ? 1 : 0);
    end
    // Flushing a bubble must leave a bubble and not count.
    step(1'b0, 1'b1, 32'h300, 32'h304, 32'h12345678, 1'b1);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL flush_bubble got=%h exp=%h", dut_obs(), e); end
    total++;
    if ({pc_o, instr_o, valid_o, flush_cnt_o} !== {32'h100, NOP, 1'b0, (PERF ? 16'd1 : 16'd0)}) begin
      bad++; $display("FAIL flush_bubble_const got=%h/%h/%b/%0d", pc_o, instr_o, valid_o, flush_cnt_o);
    end
  endtask

  task automatic test_invalid_fetch();
    obs_t e;
    step(1'b0, 1'b0, 32'h200, 32'h204, 32'hDEADBEEF, 1'b0);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL invalid got=%h exp=%h", dut_obs(), e); end
    total++;
    if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {32'h200, 32'h204, NOP, 1'b0}) begin
      bad++; $display("FAIL invalid_const got=%h/%h/%h/%b exp=200/204/00000013/0", pc_o, pc_plus4_o, instr_o, valid_o);
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    obs_t rst_v;
    rst_v = {32'h0, 32'h0, NOP, 1'b0, 16'h0, 16'h0};
    step(1'b0, 1'b0, 32'h400, 32'h404, 32'h00100073, 1'b1);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL pre_reset_load got=%h exp=%h", dut_obs(), e); end
    step(1'b1, 1'b0, 32'h404, 32'h408, 32'h0, 1'b1);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL pre_reset_stall got=%h exp=%h", dut_obs(), e); end
    @(negedge clk);
    stall_i = 1'b1; flush_i = 1'b1;
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_obs() !== rst_v) begin bad++; $display("FAIL async_reset got=%h exp=%h", dut_obs(), rst_v); end
    #20;
    stall_i = 1'b0; flush_i = 1'b0;
    rst_n = 1'b1;
    #3;
    total++;
    if (dut_obs() !== rst_v) begin bad++; $display("FAIL reset_release got=%h exp=%h", dut_obs(), rst_v); end
    model_reset();
    clk_en = 1'b1;
    step(1'b0, 1'b0, 32'h500, 32'h504, 32'h00208133, 1'b1);
    e = sb.pop_front();
    total++;
    if (dut_obs() !== e) begin bad++; $display("FAIL post_reset_load got=%h exp=%h", dut_obs(), e); end
    total++;
    if ({pc_o, instr_o, valid_o} !== {32'h500, 32'h00208133, 1'b1}) begin
      bad++; $display("FAIL post_reset_const got=%h/%h/%b", pc_o, instr_o, valid_o);
    end
  endtask

  task automatic test_random();
    obs_t e;
    logic [31:0] pc;
    for (int i = 0; i < 300; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), pc, pc + 32'd4,
           $urandom, ($urandom_range(0, 3) != 0));
      e = sb.pop_front();
      total++;
      if (dut_obs() !== e) begin bad++; $display("FAIL random%0d got=%h exp=%h", i, dut_obs(), e); end
    end
  endtask

  task automatic test_saturation();
    obs_t e;
    int n;
    int errs;
    n = PERF ? 65540 : 64;
    errs = 0;
    step(1'b0, 1'b0, 32'h600, 32'h604, 32'h00000033, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 32'h604, 32'h608, 32'h0, 1'b1);
      e = sb.pop_front();
      total++;
      if (dut_obs() !== e) begin
        bad++;
        if (errs < 5) $display("FAIL sat_cycle%0d got=%h exp=%h", i, dut_obs(), e);
        errs++;
      end
    end
    total++;
    if (PERF) begin
      if (stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt_o); end
    end else begin
      if ({stall_cnt_o, flush_cnt_o} !== 32'h0) begin
        bad++; $display("FAIL counters_off got=%h/%h exp=0/0", stall_cnt_o, flush_cnt_o);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_invalid_fetch();
    test_async_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
